modaddsub_ctrl: RTL and testbench
=================================

# modaddsub_ctrl

Sequencing controller that turns the shared multi-cycle `mpadder` into a constant-time modular adder/subtractor for the Montgomery datapath. It computes (a + b) mod m or (a − b) mod m by issuing exactly two passes to one `mpadder` instance: a raw add/sub, then a correction pass. It sits between the Montgomery top-level FSM and the adder.

## Interface
Parameters:
- `OPW`, 1026, operand/modulus width; a, b, m < 2^OPW.
- `ADDER_SIZE`, 257, chunk width forwarded to `mpadder`; adder width is OPW+1 = 1027.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  1  0 = modular add, 1 = modular subtract; latched with `start`.
- `in_a`  in  OPW  operand a, required < m; latched with `start`.
- `in_b`  in  OPW  operand b, required < m; latched with `start`.
- `in_m`  in  OPW  modulus m, required odd and nonzero; latched with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  single-cycle pulse; `result` is valid from this cycle.
- `result`  out  OPW  modular result; held until the next operation's `done`.

## Operation
- `mpadder` contract: one-cycle `start` launches; `done` marks `result[1027:0]` valid. For add, the sum includes the carry. For subtract, the result is `in_a − in_b` mod 2^1028; bit 1027 is set iff `in_a < in_b`.
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIN.
- IDLE: on `start`=1, latch `op`, a, b, m, then go to ISSUE1. `start` is ignored in every other state. No queueing.
- ISSUE1: pulse adder `start` with `in_a`={0,a}, `in_b`={0,b}, `subtract`=op. Go to WAIT1.
- WAIT1: on adder `done`, register t = adder result (1028 bits), then go to ISSUE2.
- ISSUE2, op=0: pulse adder with `in_a`=t[1026:0], `in_b`={0,m}, `subtract`=1.
- ISSUE2, op=1: pulse adder with `in_a`=t[1026:0], `in_b`={0,m}, `subtract`=0.
- WAIT2: on adder `done`, latch the result, then go to FIN.
  - op=0: if result bit 1027 = 0, take result[OPW-1:0]; else take t[OPW-1:0].
  - op=1: if t bit 1027 = 1 (a<b), take result[OPW-1:0]; else take t[OPW-1:0].
- FIN: `done`=1 for one cycle, then go to IDLE.
- Constant time: the second pass is always issued, whatever the operand values. The selection is a mux only, with no data-dependent branching of the FSM.
- Precondition violation (a≥m or b≥m): the result is unspecified. The operation still completes with identical cycle count and a `done` pulse.

## Timing
- Reset (async assert, `resetn`=0): state IDLE, `busy`=0, `done`=0, `result`=0, adder `start`=0, internal t=0.
- `resetn` deasserted: the controller accepts `start` on the first rising edge.
- Reset mid-operation: the controller aborts immediately, with no `done`. `mpadder` shares `resetn`, so no stale adder `done` survives.
- Latency: `start` sampled at edge 0 gives `done` at 2·L + 4 cycles, where L = adder start-to-done latency. The cycle count is fixed for all operand values.
- Back-to-back: `start` may be asserted in the cycle `done` is high, but it is ignored there. The earliest accepted `start` is the cycle after FIN.
- Adder `start` is high for exactly one cycle per pass, and never while the adder is busy.

## Structure
- Shared package `montgomery_pkg`: `OPW`, `ADDER_SIZE`, op encodings `OP_MODADD`=0 and `OP_MODSUB`=1, and the state enum. The Montgomery top level and the bench reuse these.
- One sub-module: the existing `mpadder` (ADDER_SIZE=257), instantiated once inside this block.
- Registers: latched operands, t (1028 b), result (OPW b), and 3-bit state.

## Test plan
- m=13, op=0, a=7, b=9 -> `done` after 2L+4 cycles, `result`=3; `busy` high throughout.
- m=13, op=1, a=3, b=9 -> `result`=7; then a=9, b=3 -> `result`=6. Latency is identical in both cases.
- m=13, op=0, a=6, b=7 (sum = m) -> `result`=0. Then a=0, b=0 under both ops -> `result`=0.
- m=2^1025+1, op=0, a=b=2^1025 -> `result`=2^1025−1. No truncation of the 1027-bit intermediate.
- `start` re-pulsed in WAIT1 with different operands -> ignored; the first operation's result is delivered, with exactly one `done`.
- `resetn` pulled low during WAIT2 -> `busy`/`done`/`result` go to 0 asynchronously. A fresh op m=13, a=12, b=12 (add) afterwards -> `result`=11.

Source files
------------

// File: rtl/montgomery_pkg.sv
// Shared constants, op encodings and controller state encoding for the Montgomery datapath.
`default_nettype none

package montgomery_pkg;

    localparam int OPW        = 1026;
    localparam int ADDER_SIZE = 257;

    localparam logic OP_MODADD = 1'b0;
    localparam logic OP_MODSUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        FIN    = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/modaddsub_ctrl_if.sv
// Request/response bundle between the Montgomery top-level FSM and the modular add/sub controller.
`default_nettype none

interface modaddsub_ctrl_if #(
    parameter int OPW = montgomery_pkg::OPW
);
    logic           start;
    logic           op;
    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;
    logic [OPW-1:0] in_m;
    logic           busy;
    logic           done;
    logic [OPW-1:0] result;

    modport master (
        output start, op, in_a, in_b, in_m,
        input  busy, done, result
    );

    modport slave (
        input  start, op, in_a, in_b, in_m,
        output busy, done, result
    );
endinterface

`default_nettype wire

// File: rtl/mpadder.sv
// Multi-cycle chunked adder/subtractor: one ADDER_SIZE-bit slice per cycle, ripple carry between slices.
`default_nettype none

module mpadder #(
    parameter int OPW        = 1026,
    parameter int ADDER_SIZE = 257
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    input  wire logic           start,
    input  wire logic           subtract,
    input  wire logic [OPW:0]   in_a,
    input  wire logic [OPW:0]   in_b,
    output logic      [OPW+1:0] result,
    output logic                done
);
    localparam int RW     = OPW + 2;
    localparam int NCHUNK = (RW + ADDER_SIZE - 1) / ADDER_SIZE;
    localparam int W      = NCHUNK * ADDER_SIZE;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    logic [W-1:0]        a_q, b_q, acc_q;
    logic                carry_q, busy_q, done_q;
    logic [CW-1:0]       cnt_q;
    logic [W-1:0]        w_a_ext, w_b_ext;
    logic [ADDER_SIZE:0] w_sum;

    // Subtraction as a + ~b + 1 over the full padded width gives a - b mod 2^W.
    assign w_a_ext = W'(in_a);
    assign w_b_ext = subtract ? ~W'(in_b) : W'(in_b);
    assign w_sum   = {1'b0, a_q[ADDER_SIZE-1:0]} + {1'b0, b_q[ADDER_SIZE-1:0]}
                   + {{ADDER_SIZE{1'b0}}, carry_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                a_q     <= w_a_ext;
                b_q     <= w_b_ext;
                carry_q <= subtract;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                acc_q   <= {w_sum[ADDER_SIZE-1:0], acc_q[W-1:ADDER_SIZE]};
                a_q     <= a_q >> ADDER_SIZE;
                b_q     <= b_q >> ADDER_SIZE;
                carry_q <= w_sum[ADDER_SIZE];
                cnt_q   <= cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign result = acc_q[RW-1:0];
    assign done   = done_q;

endmodule

`default_nettype wire

// File: rtl/modaddsub_ctrl.sv
// Constant-time modular add/subtract: raw pass plus an always-issued correction pass on one mpadder.
`default_nettype none

module modaddsub_ctrl #(
    parameter int OPW        = montgomery_pkg::OPW,
    parameter int ADDER_SIZE = montgomery_pkg::ADDER_SIZE
) (
    input wire logic        clk,
    input wire logic        resetn,
    modaddsub_ctrl_if.slave bus
);
    import montgomery_pkg::*;

    state_e         state_q, state_d;
    logic           op_q, op_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [OPW+1:0] t_q, t_d;
    logic [OPW-1:0] result_q, result_d;
    logic           add_start_q, add_start_d;

    logic           w_pass2, w_add_sub, w_add_done, w_take_r, w_unused;
    logic [OPW:0]   w_add_a, w_add_b;
    logic [OPW+1:0] w_add_res;

    // Operands are steered by the current state; the adder captures them on its start cycle.
    assign w_pass2   = (state_q == ISSUE2);
    assign w_add_a   = w_pass2 ? t_q[OPW:0]   : {1'b0, a_q};
    assign w_add_b   = w_pass2 ? {1'b0, m_q}  : {1'b0, b_q};
    assign w_add_sub = w_pass2 ? ~op_q        : op_q;

    // Add: keep the reduced value unless it went negative. Sub: add m back only if a<b.
    assign w_take_r  = (op_q == OP_MODADD) ? ~w_add_res[OPW+1] : t_q[OPW+1];
    assign w_unused  = w_add_res[OPW];

    mpadder #(
        .OPW        (OPW),
        .ADDER_SIZE (ADDER_SIZE)
    ) u_mpadder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start_q),
        .subtract (w_add_sub),
        .in_a     (w_add_a),
        .in_b     (w_add_b),
        .result   (w_add_res),
        .done     (w_add_done)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        t_d      = t_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    m_d     = bus.in_m;
                    state_d = ISSUE1;
                end
            end
            ISSUE1: state_d = WAIT1;
            WAIT1: begin
                if (w_add_done) begin
                    t_d     = w_add_res;
                    state_d = ISSUE2;
                end
            end
            ISSUE2: state_d = WAIT2;
            WAIT2: begin
                if (w_add_done) begin
                    result_d = w_take_r ? w_add_res[OPW-1:0] : t_q[OPW-1:0];
                    state_d  = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        add_start_d = (state_d == ISSUE1) || (state_d == ISSUE2);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            t_q         <= '0;
            result_q    <= '0;
            add_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            t_q         <= t_d;
            result_q    <= result_d;
            add_start_q <= add_start_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == FIN);
    assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_modaddsub_ctrl.sv
// Directed bench for modaddsub_ctrl: hand-computed modular results, fixed latency, ignored starts, async reset.
`default_nettype none

module tb_modaddsub_ctrl;
    import montgomery_pkg::*;

    localparam int EXP_LAT = 12;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    modaddsub_ctrl_if #(.OPW(OPW)) bus ();

    modaddsub_ctrl #(
        .OPW        (OPW),
        .ADDER_SIZE (ADDER_SIZE)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; repulse>0 re-asserts start with other operands in that cycle.
    task automatic run_op(input string tag, input logic op, input logic [OPW-1:0] a,
                          input logic [OPW-1:0] b, input logic [OPW-1:0] m,
                          input logic [OPW-1:0] exp, input int repulse);
        int   c;
        int   lat;
        int   ndone;
        logic busy_ok;
        bus.start = 1'b1;
        bus.op    = op;
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_m  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_a  = ~a;
        bus.in_b  = ~b;
        bus.in_m  = ~m;
        c = 0; lat = 0; ndone = 0; busy_ok = 1'b1;
        while (ndone == 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                lat = c;
            end
            if (c == repulse) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.in_a  = 1;
                bus.in_b  = 2;
                bus.in_m  = 13;
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, ".latency"}, lat, EXP_LAT);
        check({tag, ".result"}, bus.result, exp);
        check({tag, ".busy"}, busy_ok, 1'b1);
        // Start in the done cycle must be ignored.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, ".busy_after"}, bus.busy, 1'b0);
        check({tag, ".done_pulse"}, bus.done, 1'b0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        check({tag, ".extra_done"}, ndone, 0);
        check({tag, ".held"}, bus.result, exp);
    endtask

    initial begin
        logic [OPW-1:0] m_big;
        logic [OPW-1:0] v_big;
        logic [OPW-1:0] e_big;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        bus.in_m  = '0;
        #2;
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.result", bus.result, '0);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op("add_7_9",  OP_MODADD, 7, 9, 13, 3, 0);
        run_op("sub_3_9",  OP_MODSUB, 3, 9, 13, 7, 0);
        run_op("sub_9_3",  OP_MODSUB, 9, 3, 13, 6, 0);
        run_op("add_6_7",  OP_MODADD, 6, 7, 13, 0, 0);
        run_op("add_0_0",  OP_MODADD, 0, 0, 13, 0, 0);
        run_op("sub_0_0",  OP_MODSUB, 0, 0, 13, 0, 0);

        m_big = (OPW'(1) << 1025) + OPW'(1);
        v_big = OPW'(1) << 1025;
        e_big = (OPW'(1) << 1025) - OPW'(1);
        run_op("add_big",  OP_MODADD, v_big, v_big, m_big, e_big, 0);

        run_op("repulse",  OP_MODADD, 7, 9, 13, 3, 3);

        // Abort during WAIT2 (cycles 7..11 after acceptance).
        bus.start = 1'b1;
        bus.op    = OP_MODADD;
        bus.in_a  = 12;
        bus.in_b  = 5;
        bus.in_m  = 13;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        check("abort.busy", bus.busy, 1'b0);
        check("abort.done", bus.done, 1'b0);
        check("abort.result", bus.result, '0);
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("abort.no_done", bus.done, 1'b0);

        run_op("add_12_12", OP_MODADD, 12, 12, 13, 11, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
